ysyx_23060184_icache: RTL and testbench
=======================================

Name: ysyx_23060184_icache

Overview:
- Direct-mapped, read-only instruction cache between the IFU instruction-fetch AXI4-Lite read port and the arbitrated SRAM read channel.
- Hits return a word without an SRAM transaction.
- A miss refills the whole line with sequential single-beat reads, then responds.
- Supports full invalidation (fence.i) and exposes hit and miss counters.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, word width.
- NUM_LINES, 16, number of lines; power of two, at least 2.
- LINE_WORDS, 4, words per line; power of two, at least 2.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset.
- araddr  in  ADDR_WIDTH  fetch address from IFU.
- arvalid  in  1  fetch request valid.
- arready  out  1  cache accepts a request.
- rdata  out  DATA_WIDTH  instruction word.
- rresp  out  2  0 = OKAY, otherwise error passed through from memory.
- rvalid  out  1  response valid.
- rready  in  1  IFU accepts the response.
- m_araddr  out  ADDR_WIDTH  refill address to the arbiter/SRAM.
- m_arvalid  out  1  refill request valid.
- m_arready  in  1  memory accepts the address.
- m_rdata  in  DATA_WIDTH  refill data.
- m_rresp  in  2  refill response.
- m_rvalid  in  1  refill data valid.
- m_rready  out  1  cache accepts refill data.
- fence_i  in  1  one-cycle pulse: invalidate all lines.
- hit_cnt  out  32  number of hits.
- miss_cnt  out  32  number of misses.

Behaviour:
- Interface (already decided): one clock, clk. Reset rstn is asynchronous and active-low.
- Address split:
  - Offset = araddr[OFF-1:2], where OFF = log2(LINE_WORDS) + 2. Bits [1:0] are ignored.
  - Index = next log2(NUM_LINES) bits.
  - Tag = the remaining upper bits.
- Reset values:
  - State IDLE; all valid bits 0.
  - rvalid = 0, rdata = 0, rresp = 0.
  - m_arvalid = 0, m_rready = 0.
  - hit_cnt = 0, miss_cnt = 0.
  - arready = 1 (decoded from IDLE).
  - Tag and data arrays are not reset.
- States:
  - IDLE: arready = 1. When arvalid is high, latch araddr and go to LOOKUP.
  - LOOKUP: if valid[index] and tag matches (hit), load rdata from the array, set rresp = 0, increment hit_cnt, go to RESP. Otherwise (miss), increment miss_cnt, clear word counter cnt and the error flag, go to REFILL_AR.
  - REFILL_AR: m_arvalid = 1, m_araddr = {tag, index, cnt, 2'b00}. m_araddr stays stable until m_arready, then go to REFILL_R.
  - REFILL_R: m_rready = 1. On m_rvalid:
    - write m_rdata to word cnt of the line;
    - if cnt equals the requested offset, capture the word into rdata;
    - OR (m_rresp != 0) into the error flag;
    - if cnt = LINE_WORDS-1, go to RESP; otherwise increment cnt and return to REFILL_AR.
  - RESP: rvalid = 1. rdata and rresp stay stable until rready, then go to IDLE.
  - Refill completion: on entry to RESP after a refill, rresp = error flag ? last nonzero m_rresp : 0. Tag and valid are written only if the error flag is clear and no fence occurred during the refill.
- Latency:
  - Hit: handshake in cycle 0, rvalid in cycle 2.
  - Miss: cycle 2 + LINE_WORDS × (memory round trip) before rvalid.
  - Throughput: at most one request in flight; the next request is accepted the cycle after the rready handshake.
- fence_i:
  - In any state, clears all valid bits in that cycle.
  - During a refill, sets a flag so the refilled line is not marked valid. The current response still returns the fetched data.
  - In IDLE together with arvalid: the invalidate takes effect first, and the request is accepted and misses.
- Miss address wrap: the refill always starts at word 0 of the line (no critical-word-first).
- Counters wrap modulo 2^32.
- Reset asserted mid-refill: return to IDLE at once and clear all valids. No AXI transaction completion is guaranteed to memory; the arbiter is reset in the same domain.
- Protocol: m_arvalid, once high, is not dropped before m_arready. The cache never has more than one outstanding memory read.

Decomposition:
- Width constants go in the shared configuration header: ICACHE_LINES, ICACHE_LINE_WORDS, derived offset/index/tag widths, and the response codes (reuse ACERR_WIDTH).
- One sub-module, ysyx_23060184_icache_array:
  - tag + valid + data storage;
  - synchronous write of one word per cycle;
  - tag/valid write at refill end;
  - global valid clear;
  - combinational read by index/offset.
- The FSM, counters and AXI logic stay in the top module.

Test Plan:
- Cold fetch at 0x80000000 with memory returning 0x11,0x22,0x33,0x44 at 0x80000000..0x8000000C, rresp=0 -> four m_ar at 0x80000000/4/8/C; rdata=0x11, rresp=0; miss_cnt=1.
- Then fetch 0x80000008 -> no m_arvalid; rvalid 2 cycles after handshake; rdata=0x33; hit_cnt=1.
- Fetch 0x80000100, which has the same index as 0x80000000 with a different tag -> refill at 0x80000100; a later fetch of 0x80000000 misses again; miss_cnt=3.
- fence_i pulse during the second REFILL_R beat of a fetch at 0x80000040 -> response still returns the correct word; an immediate refetch of 0x80000040 misses.
- Memory returns rresp=2 on the third beat for fetch 0x80000080 -> rresp=2 at RESP; line not valid; refetch issues a refill.
- rready held low 5 cycles in RESP -> rvalid, rdata and rresp remain stable; arready=0 throughout. Asserting rstn=0 mid-refill -> next cycle: IDLE, rvalid=0, m_arvalid=0, and a later fetch of the same address misses.

Source files
------------

// File: rtl/ysyx_23060184_icache_pkg.sv
// Shared configuration for the instruction cache: geometry, derived field widths,
// response codes and the controller state type.
package ysyx_23060184_icache_pkg;

  localparam int unsigned ICACHE_ADDR_WIDTH = 32;
  localparam int unsigned ICACHE_DATA_WIDTH = 32;
  localparam int unsigned ICACHE_LINES      = 16;
  localparam int unsigned ICACHE_LINE_WORDS = 4;

  // Address split: | tag | index | word offset | byte (ignored) |
  localparam int unsigned ICACHE_WORD_WIDTH = $clog2(ICACHE_LINE_WORDS);
  localparam int unsigned ICACHE_OFF_WIDTH  = ICACHE_WORD_WIDTH + 2;
  localparam int unsigned ICACHE_IDX_WIDTH  = $clog2(ICACHE_LINES);
  localparam int unsigned ICACHE_TAG_WIDTH  =
      ICACHE_ADDR_WIDTH - ICACHE_OFF_WIDTH - ICACHE_IDX_WIDTH;

  localparam int unsigned ACERR_WIDTH = 2;
  localparam logic [ACERR_WIDTH-1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StRefillAr,
    StRefillR,
    StResp
  } icache_state_e;

endpackage

// File: rtl/ysyx_23060184_icache_array.sv
// Tag, valid and data storage for the direct-mapped instruction cache.
// One data word written per cycle; tag/valid written once a refill completes.
module ysyx_23060184_icache_array #(
  parameter int unsigned NUM_LINES  = 16,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned TAG_WIDTH  = 24,
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned IdxW      = $clog2(NUM_LINES),
  localparam int unsigned WordW     = $clog2(LINE_WORDS)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clear,
  input  logic                  data_we,
  input  logic [IdxW-1:0]       wr_index,
  input  logic [WordW-1:0]      wr_offset,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  tag_we,
  input  logic [TAG_WIDTH-1:0]  wr_tag,
  input  logic [IdxW-1:0]       rd_index,
  input  logic [WordW-1:0]      rd_offset,
  output logic                  rd_valid,
  output logic [TAG_WIDTH-1:0]  rd_tag,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [NUM_LINES-1:0]  valid_q;
  logic [TAG_WIDTH-1:0]  tag_q  [NUM_LINES];
  logic [DATA_WIDTH-1:0] data_q [NUM_LINES*LINE_WORDS];

  // Valid bits: global clear wins; a line is marked valid when its refill commits.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= '0;
    end else if (clear) begin
      valid_q <= '0;
    end else if (tag_we) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (data_we) begin
      data_q[{wr_index, wr_offset}] <= wr_data;
    end
    if (tag_we) begin
      tag_q[wr_index] <= wr_tag;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[{rd_index, rd_offset}];

endmodule

// File: rtl/ysyx_23060184_icache.sv
// Direct-mapped read-only instruction cache between the IFU fetch port and the
// SRAM read channel. Misses refill the whole line with single-beat reads, word 0 first.
module ysyx_23060184_icache
  import ysyx_23060184_icache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ICACHE_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = ICACHE_DATA_WIDTH,
  parameter int unsigned NUM_LINES  = ICACHE_LINES,
  parameter int unsigned LINE_WORDS = ICACHE_LINE_WORDS
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [ADDR_WIDTH-1:0]  araddr,
  input  logic                   arvalid,
  output logic                   arready,
  output logic [DATA_WIDTH-1:0]  rdata,
  output logic [ACERR_WIDTH-1:0] rresp,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [ADDR_WIDTH-1:0]  m_araddr,
  output logic                   m_arvalid,
  input  logic                   m_arready,
  input  logic [DATA_WIDTH-1:0]  m_rdata,
  input  logic [ACERR_WIDTH-1:0] m_rresp,
  input  logic                   m_rvalid,
  output logic                   m_rready,
  input  logic                   fence_i,
  output logic [31:0]            hit_cnt,
  output logic [31:0]            miss_cnt
);

  localparam int unsigned WordW = $clog2(LINE_WORDS);
  localparam int unsigned OffW  = WordW + 2;
  localparam int unsigned IdxW  = $clog2(NUM_LINES);
  localparam int unsigned TagW  = ADDR_WIDTH - OffW - IdxW;
  localparam logic [WordW-1:0] LastWord = WordW'(LINE_WORDS - 1);

  icache_state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [WordW-1:0]       cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic [ACERR_WIDTH-1:0] err_resp_q, err_resp_d;
  logic                   fence_q, fence_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic [ACERR_WIDTH-1:0] rresp_q, rresp_d;
  logic [31:0]            hit_cnt_q, hit_cnt_d;
  logic [31:0]            miss_cnt_q, miss_cnt_d;

  logic [WordW-1:0]      req_word;
  logic [IdxW-1:0]       req_idx;
  logic [TagW-1:0]       req_tag;
  logic                  arr_valid;
  logic [TagW-1:0]       arr_tag;
  logic [DATA_WIDTH-1:0] arr_data;
  logic                  data_we;
  logic                  tag_we;
  logic                  hit;
  logic                  unused_byte_bits;

  assign req_word = addr_q[OffW-1:2];
  assign req_idx  = addr_q[OffW+IdxW-1:OffW];
  assign req_tag  = addr_q[ADDR_WIDTH-1:OffW+IdxW];
  assign unused_byte_bits = ^addr_q[1:0];

  ysyx_23060184_icache_array #(
    .NUM_LINES  (NUM_LINES),
    .LINE_WORDS (LINE_WORDS),
    .TAG_WIDTH  (TagW),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (fence_i),
    .data_we   (data_we),
    .wr_index  (req_idx),
    .wr_offset (cnt_q),
    .wr_data   (m_rdata),
    .tag_we    (tag_we),
    .wr_tag    (req_tag),
    .rd_index  (req_idx),
    .rd_offset (req_word),
    .rd_valid  (arr_valid),
    .rd_tag    (arr_tag),
    .rd_data   (arr_data)
  );

  // A fence in the lookup cycle invalidates before the lookup can hit.
  assign hit = arr_valid && (arr_tag == req_tag) && !fence_i;

  // Next-state, datapath and array write controls.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    err_resp_d = err_resp_q;
    fence_d    = fence_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    data_we    = 1'b0;
    tag_we     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (arvalid) begin
          addr_d  = araddr;
          state_d = StLookup;
        end
      end
      StLookup: begin
        if (hit) begin
          rdata_d   = arr_data;
          rresp_d   = RESP_OKAY;
          hit_cnt_d = hit_cnt_q + 32'd1;
          state_d   = StResp;
        end else begin
          miss_cnt_d = miss_cnt_q + 32'd1;
          cnt_d      = '0;
          err_d      = 1'b0;
          err_resp_d = RESP_OKAY;
          fence_d    = 1'b0;
          state_d    = StRefillAr;
        end
      end
      StRefillAr: begin
        if (fence_i) fence_d = 1'b1;
        if (m_arready) state_d = StRefillR;
      end
      StRefillR: begin
        if (fence_i) fence_d = 1'b1;
        if (m_rvalid) begin
          data_we = 1'b1;
          if (cnt_q == req_word) rdata_d = m_rdata;
          if (m_rresp != RESP_OKAY) begin
            err_d      = 1'b1;
            err_resp_d = m_rresp;
          end
          if (cnt_q == LastWord) begin
            rresp_d = err_d ? err_resp_d : RESP_OKAY;
            // Commit the line only if it is clean and no fence raced the refill.
            tag_we  = !err_d && !fence_q && !fence_i;
            state_d = StResp;
          end else begin
            cnt_d   = cnt_q + WordW'(1);
            state_d = StRefillAr;
          end
        end
      end
      StResp: begin
        if (rready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      err_resp_q <= RESP_OKAY;
      fence_q    <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      err_resp_q <= err_resp_d;
      fence_q    <= fence_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign arready   = (state_q == StIdle);
  assign rvalid    = (state_q == StResp);
  assign m_arvalid = (state_q == StRefillAr);
  assign m_rready  = (state_q == StRefillR);
  assign m_araddr  = {req_tag, req_idx, cnt_q, 2'b00};
  assign rdata     = rdata_q;
  assign rresp     = rresp_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_ysyx_23060184_icache.sv
// Self-checking bench for the instruction cache: directed scenarios followed by random
// fetches, checked against a line-level cache model and a simple memory responder.
module tb_ysyx_23060184_icache;

  logic        clk;
  logic        rstn;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] m_araddr;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rvalid;
  logic        m_rready;
  logic        fence_i;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  ysyx_23060184_icache dut (
    .clk       (clk),
    .rstn      (rstn),
    .araddr    (araddr),
    .arvalid   (arvalid),
    .arready   (arready),
    .rdata     (rdata),
    .rresp     (rresp),
    .rvalid    (rvalid),
    .rready    (rready),
    .m_araddr  (m_araddr),
    .m_arvalid (m_arvalid),
    .m_arready (m_arready),
    .m_rdata   (m_rdata),
    .m_rresp   (m_rresp),
    .m_rvalid  (m_rvalid),
    .m_rready  (m_rready),
    .fence_i   (fence_i),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  // Model: 16 lines of 4 words; index = (addr/16)%16, tag = addr/256.
  bit          mdl_valid [16];
  logic [23:0] mdl_tag   [16];
  int          n_hit;
  int          n_miss;

  logic [31:0] ar_log[$];
  logic [31:0] err_addr;
  logic [1:0]  err_code;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h8000_0000: return 32'h11;
      32'h8000_0004: return 32'h22;
      32'h8000_0008: return 32'h33;
      32'h8000_000C: return 32'h44;
      default:       return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory responder: random ready, one outstanding read, random data latency.
  initial begin
    bit          ar_fire;
    bit          r_fire;
    bit          pend;
    int          dly;
    logic [31:0] s_addr;
    logic [31:0] pend_addr;
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    m_rdata   = '0;
    m_rresp   = 2'b00;
    pend      = 1'b0;
    dly       = 0;
    pend_addr = '0;
    forever begin
      @(negedge clk);
      ar_fire = m_arvalid && m_arready;
      r_fire  = m_rvalid && m_rready;
      s_addr  = m_araddr;
      @(posedge clk);
      #1;
      if (!rstn) begin
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        pend      = 1'b0;
      end else begin
        if (r_fire) m_rvalid = 1'b0;
        if (ar_fire) begin
          pend      = 1'b1;
          pend_addr = s_addr;
          dly       = $urandom_range(0, 2);
          ar_log.push_back(s_addr);
        end
        if (pend && !m_rvalid) begin
          if (dly == 0) begin
            m_rvalid = 1'b1;
            m_rdata  = mem_word(pend_addr);
            m_rresp  = (pend_addr == err_addr) ? err_code : 2'b00;
            pend     = 1'b0;
          end else begin
            dly--;
          end
        end
        m_arready = !pend && !m_rvalid && ($urandom_range(0, 3) != 0);
      end
    end
  end

  // One complete fetch: request, wait for response, optional stall, handshake, model update.
  task automatic fetch(input logic [31:0] addr, input bit do_fence, input int hold);
    logic [31:0] base;
    int          idx;
    logic [23:0] tg;
    bit          hit;
    bit          err;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    int          cyc;
    bit          got;
    bit          fire;
    bit          fence_done;
    base     = addr & 32'hFFFF_FFF0;
    idx      = int'((addr >> 4) % 16);
    tg       = 24'(addr >> 8);
    hit      = mdl_valid[idx] && (mdl_tag[idx] == tg);
    err      = !hit && (err_code != 2'b00) && (err_addr >= base) && (err_addr < base + 32'd16);
    exp_data = mem_word(addr & 32'hFFFF_FFFC);
    exp_resp = err ? err_code : 2'b00;
    ar_log.delete();

    @(posedge clk);
    #1;
    araddr  = addr;
    arvalid = 1'b1;
    @(negedge clk);
    check("arready_idle", 32'(arready), 32'd1);
    @(posedge clk);
    #1;
    arvalid    = 1'b0;
    araddr     = $urandom;
    cyc        = 1;
    got        = 1'b0;
    fence_done = 1'b0;
    while (!got && cyc < 300) begin
      @(negedge clk);
      if (rvalid) begin
        got = 1'b1;
      end else begin
        fire = do_fence && !fence_done && m_rready && (ar_log.size() == 2);
        @(posedge clk);
        #1;
        fence_i = fire;
        if (fire) fence_done = 1'b1;
        cyc++;
      end
    end
    fence_i = 1'b0;
    check("rvalid_seen", 32'(got), 32'd1);
    check("rdata", rdata, exp_data);
    check("rresp", 32'(rresp), 32'(exp_resp));
    if (hit) begin
      check("hit_latency", 32'(cyc), 32'd2);
      check("hit_no_refill", 32'(ar_log.size()), 32'd0);
    end else begin
      check("refill_beats", 32'(ar_log.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
        if (ar_log.size() == 4) check("refill_addr", ar_log[i], base + 32'(4 * i));
      end
    end

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_rvalid", 32'(rvalid), 32'd1);
      check("hold_rdata", rdata, exp_data);
      check("hold_rresp", 32'(rresp), 32'(exp_resp));
      check("hold_arready", 32'(arready), 32'd0);
    end
    rready = 1'b1;
    @(posedge clk);
    #1;
    rready = 1'b0;

    if (hit) begin
      n_hit++;
    end else begin
      n_miss++;
      if (fence_done) begin
        for (int i = 0; i < 16; i++) mdl_valid[i] = 1'b0;
      end else if (!err) begin
        mdl_valid[idx] = 1'b1;
        mdl_tag[idx]   = tg;
      end
    end
    @(negedge clk);
    check("arready_after", 32'(arready), 32'd1);
    check("rvalid_after", 32'(rvalid), 32'd0);
    check("hit_cnt", hit_cnt, 32'(n_hit));
    check("miss_cnt", miss_cnt, 32'(n_miss));
  endtask

  initial begin
    bit reached;
    total    = 0;
    bad      = 0;
    n_hit    = 0;
    n_miss   = 0;
    err_addr = 32'hFFFF_FFFF;
    err_code = 2'b00;
    for (int i = 0; i < 16; i++) begin
      mdl_valid[i] = 1'b0;
      mdl_tag[i]   = '0;
    end
    rstn    = 1'b0;
    araddr  = '0;
    arvalid = 1'b0;
    rready  = 1'b0;
    fence_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_arready", 32'(arready), 32'd1);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_rresp", 32'(rresp), 32'd0);
    check("rst_m_arvalid", 32'(m_arvalid), 32'd0);
    check("rst_m_rready", 32'(m_rready), 32'd0);
    check("rst_hit_cnt", hit_cnt, 32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Cold miss, then hit in the same line.
    fetch(32'h8000_0000, 1'b0, 0);
    fetch(32'h8000_0008, 1'b0, 0);
    // Conflict on index 0 evicts, then the original address misses again.
    fetch(32'h8000_0100, 1'b0, 0);
    fetch(32'h8000_0000, 1'b0, 0);
    // Fence during the second beat: data still returned, line not kept.
    fetch(32'h8000_0040, 1'b1, 0);
    fetch(32'h8000_0040, 1'b0, 0);
    // Error on the third beat: code propagated, line not kept, refetch refills.
    err_addr = 32'h8000_0088;
    err_code = 2'b10;
    fetch(32'h8000_0080, 1'b0, 0);
    err_code = 2'b00;
    fetch(32'h8000_0084, 1'b0, 0);
    // Response stalled for five cycles.
    fetch(32'h8000_008C, 1'b0, 5);

    // Reset in the middle of a refill.
    ar_log.delete();
    @(posedge clk);
    #1;
    araddr  = 32'h8000_00C0;
    arvalid = 1'b1;
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 100 && !reached; i++) begin
      @(negedge clk);
      if (ar_log.size() == 2) reached = 1'b1;
    end
    check("midrefill_reached", 32'(reached), 32'd1);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    @(negedge clk);
    check("midrst_arready", 32'(arready), 32'd1);
    check("midrst_rvalid", 32'(rvalid), 32'd0);
    check("midrst_m_arvalid", 32'(m_arvalid), 32'd0);
    check("midrst_m_rready", 32'(m_rready), 32'd0);
    check("midrst_miss_cnt", miss_cnt, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rstn   = 1'b1;
    n_hit  = 0;
    n_miss = 0;
    for (int i = 0; i < 16; i++) mdl_valid[i] = 1'b0;
    fetch(32'h8000_00C0, 1'b0, 0);
    fetch(32'h8000_00C4, 1'b0, 0);

    // Random fetches over a few tags per index, with occasional errors, fences and stalls.
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = 32'h8000_0000 | (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin
        err_addr = (a & 32'hFFFF_FFF0) | (32'($urandom_range(0, 3)) << 2);
        err_code = 2'($urandom_range(1, 3));
      end else begin
        err_code = 2'b00;
      end
      fetch(a, ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
